// File: rtl/display_source_arbiter_if.sv
// Display-sharing bus: per-source requests/values in, the selected value and owner status out.
// master is the requester side (the sources), slave is the arbiter.
interface display_source_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 3
);
    logic [NUM_SRC-1:0]    req_in;
    logic [NUM_SRC*32-1:0] val_in;
    logic                  hold_in;
    logic [31:0]           val_out;
    logic [SEL_W-1:0]      src_out;
    logic                  valid_out;
    logic                  switch_out;

    modport master (
        output req_in, val_in, hold_in,
        input  val_out, src_out, valid_out, switch_out
    );

    modport slave (
        input  req_in, val_in, hold_in,
        output val_out, src_out, valid_out, switch_out
    );
endinterface

// File: rtl/display_source_arbiter.sv
// Round-robin owner of the seven-segment value, with a minimum dwell per owner and a hold that freezes rotation.
//   state  | meaning
//   S_IDLE | no source owns the display, val_out forced to zero
//   S_SHOW | src_out owns the display, val_out tracks its live value
module display_source_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int SEL_W        = 3
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    display_source_arbiter_if.slave bus
);
    localparam int               CNT_W     = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int               NSEL      = 1 << SEL_W;
    localparam logic [SEL_W:0]   NUM_SRC_W = (SEL_W+1)'(NUM_SRC);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic {S_IDLE, S_SHOW} state_t;

    state_t             r_state, w_state_nxt;
    logic [31:0]        r_val, w_val_nxt;
    logic [SEL_W-1:0]   r_src, w_src_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_switch, w_switch_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;

    logic [NSEL-1:0]        w_req_pad;
    logic [31:0]            w_val_arr [NSEL];
    logic [NUM_SRC-1:0]     w_excl, w_req_mask, w_rot;
    logic [2*NUM_SRC-1:0]   w_req2;
    logic [SEL_W-1:0]       w_start, w_win;
    logic                   w_found;

    function automatic logic [SEL_W-1:0] f_wrap_add(input logic [SEL_W-1:0] a, input logic [SEL_W:0] b);
        logic [SEL_W:0] s;
        s = {1'b0, a} + b;
        if (s >= NUM_SRC_W) s = s - NUM_SRC_W;
        return s[SEL_W-1:0];
    endfunction

    // Pad to a power of two so the SEL_W-bit owner index addresses these directly.
    for (genvar g = 0; g < NSEL; g++) begin : g_val
        if (g < NUM_SRC) begin : g_src
            assign w_val_arr[g] = bus.val_in[32*g +: 32];
        end else begin : g_pad
            assign w_val_arr[g] = '0;
        end
    end
    assign w_req_pad = NSEL'(bus.req_in);

    // In SHOW the search starts after the owner and never re-picks it; in IDLE it starts at the pointer.
    assign w_excl     = (r_state == S_SHOW) ? (NUM_SRC'(1) << r_src) : '0;
    assign w_start    = (r_state == S_SHOW) ? f_wrap_add(r_src, (SEL_W+1)'(1)) : r_ptr;
    assign w_req_mask = bus.req_in & ~w_excl;
    assign w_req2     = {w_req_mask, w_req_mask};
    assign w_rot      = NUM_SRC'(w_req2 >> w_start);

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_win   = f_wrap_add(w_start, (SEL_W+1)'(i));
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_val_nxt    = r_val;
        w_src_nxt    = r_src;
        w_valid_nxt  = r_valid;
        w_switch_nxt = 1'b0;
        w_cnt_nxt    = r_cnt;
        w_ptr_nxt    = r_ptr;
        case (r_state)
            S_IDLE: begin
                w_val_nxt   = '0;
                w_valid_nxt = 1'b0;
                if (w_found) begin
                    w_state_nxt  = S_SHOW;
                    w_src_nxt    = w_win;
                    w_val_nxt    = w_val_arr[w_win];
                    w_valid_nxt  = 1'b1;
                    w_switch_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                    w_ptr_nxt    = f_wrap_add(w_win, (SEL_W+1)'(1));
                end
            end
            S_SHOW: begin
                if (!w_req_pad[r_src] || (!bus.hold_in && r_cnt == CNT_LAST)) begin
                    w_cnt_nxt = '0;
                    if (w_found) begin
                        w_src_nxt    = w_win;
                        w_val_nxt    = w_val_arr[w_win];
                        w_valid_nxt  = 1'b1;
                        w_switch_nxt = 1'b1;
                        w_ptr_nxt    = f_wrap_add(w_win, (SEL_W+1)'(1));
                    end else if (!w_req_pad[r_src]) begin
                        w_state_nxt = S_IDLE;
                        w_val_nxt   = '0;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_val_nxt = w_val_arr[r_src];
                    end
                end else begin
                    w_val_nxt = w_val_arr[r_src];
                    if (!bus.hold_in) w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state  <= S_IDLE;
            r_val    <= '0;
            r_src    <= '0;
            r_valid  <= 1'b0;
            r_switch <= 1'b0;
            r_cnt    <= '0;
            r_ptr    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_val    <= w_val_nxt;
            r_src    <= w_src_nxt;
            r_valid  <= w_valid_nxt;
            r_switch <= w_switch_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

    assign bus.val_out    = r_val;
    assign bus.src_out    = r_src;
    assign bus.valid_out  = r_valid;
    assign bus.switch_out = r_switch;
endmodule

// File: tb/tb_display_source_arbiter.sv
// Directed bench for display_source_arbiter: 4 sources, 8-cycle dwell, hand-computed expectations.
module tb_display_source_arbiter;
    localparam int NUM_SRC = 4;
    localparam int DWELL   = 8;
    localparam int SEL_W   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    display_source_arbiter_if #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) dut_if ();

    display_source_arbiter #(
        .NUM_SRC(NUM_SRC), .DWELL_CYCLES(DWELL), .SEL_W(SEL_W)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .bus   (dut_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_val(input int s, input logic [31:0] v);
        dut_if.val_in[32*s +: 32] = v;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        dut_if.req_in  = '0;
        dut_if.hold_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_sw;
        int got;
        int exp_own;
        dut_if.req_in  = '0;
        dut_if.hold_in = 1'b0;
        dut_if.val_in  = '0;
        for (int s = 0; s < NUM_SRC; s++) set_val(s, 32'hA000_0000 + s);

        // reset values
        #2 rst_n = 1'b0;
        #2;
        chk("rst_val",    dut_if.val_out,    32'h0);
        chk("rst_src",    dut_if.src_out,    32'h0);
        chk("rst_valid",  dut_if.valid_out,  32'h0);
        chk("rst_switch", dut_if.switch_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // single requester grant from idle
        set_val(2, 32'hDEADBEEF);
        dut_if.req_in = 4'b0100;
        tick();
        chk("t1_src",    dut_if.src_out,    32'd2);
        chk("t1_val",    dut_if.val_out,    32'hDEADBEEF);
        chk("t1_valid",  dut_if.valid_out,  32'd1);
        chk("t1_switch", dut_if.switch_out, 32'd1);
        tick();
        chk("t1_pulse_end", dut_if.switch_out, 32'd0);
        dut_if.req_in = 4'b0000;
        tick();
        chk("t1_idle_valid", dut_if.valid_out, 32'd0);
        chk("t1_idle_val",   dut_if.val_out,   32'd0);
        dut_if.req_in = 4'b1010;
        tick();
        chk("t1_ptr_src", dut_if.src_out, 32'd3);

        // two sources alternate every dwell, value tracks live input
        apply_reset();
        dut_if.req_in = 4'b0011;
        set_val(0, 32'd100);
        set_val(1, 32'd200);
        tick();
        chk("t2_grant_src", dut_if.src_out,    32'd0);
        chk("t2_grant_sw",  dut_if.switch_out, 32'd1);
        chk("t2_grant_val", dut_if.val_out,    32'd100);
        for (int k = 1; k <= 4 * DWELL; k++) begin
            set_val(0, 32'(100 + k));
            set_val(1, 32'(200 + k));
            tick();
            exp_own = ((k / DWELL) % 2 == 0) ? 0 : 1;
            chk("t2_src", dut_if.src_out, 32'(exp_own));
            chk("t2_sw",  dut_if.switch_out, (k % DWELL == 0) ? 32'd1 : 32'd0);
            chk("t2_val", dut_if.val_out, (exp_own == 0) ? 32'(100 + k) : 32'(200 + k));
        end

        // lone requester is retained across dwell expiries
        apply_reset();
        dut_if.req_in = 4'b1000;
        tick();
        chk("t3_grant_src", dut_if.src_out,    32'd3);
        chk("t3_grant_sw",  dut_if.switch_out, 32'd1);
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("t3_src", dut_if.src_out,    32'd3);
            chk("t3_sw",  dut_if.switch_out, 32'd0);
        end

        // owner drop mid-dwell, then last requester drops
        apply_reset();
        set_val(1, 32'h1111_1111);
        set_val(3, 32'h3333_3333);
        dut_if.req_in = 4'b0010;
        tick();
        chk("t4_grant_src", dut_if.src_out, 32'd1);
        dut_if.req_in = 4'b1010;
        tick();
        tick();
        dut_if.req_in = 4'b1000;
        tick();
        chk("t4_drop_src", dut_if.src_out,    32'd3);
        chk("t4_drop_sw",  dut_if.switch_out, 32'd1);
        chk("t4_drop_val", dut_if.val_out,    32'h3333_3333);
        dut_if.req_in = 4'b0000;
        tick();
        chk("t4_idle_valid", dut_if.valid_out,  32'd0);
        chk("t4_idle_val",   dut_if.val_out,    32'd0);
        chk("t4_idle_sw",    dut_if.switch_out, 32'd0);
        tick();
        chk("t4_idle_stay", dut_if.valid_out, 32'd0);

        // hold freezes the counter mid-dwell without clearing it
        apply_reset();
        dut_if.req_in = 4'b1111;
        tick();
        chk("t5_grant_src", dut_if.src_out, 32'd0);
        tick();
        tick();
        tick();
        dut_if.hold_in = 1'b1;
        n_sw = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (dut_if.switch_out) n_sw++;
            chk("t5_hold_src", dut_if.src_out, 32'd0);
        end
        chk("t5_hold_sw_count", 32'(n_sw), 32'd0);
        dut_if.hold_in = 1'b0;
        got = 20;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (dut_if.switch_out && got == 20) got = c;
            if (got != 20) break;
        end
        chk("t5_resume_cycles", 32'(got), 32'd5);
        chk("t5_resume_src",    dut_if.src_out, 32'd1);
        dut_if.hold_in = 1'b1;
        dut_if.req_in  = 4'b1101;
        tick();
        chk("t5_drop_under_hold_src", dut_if.src_out,    32'd2);
        chk("t5_drop_under_hold_sw",  dut_if.switch_out, 32'd1);
        dut_if.hold_in = 1'b0;

        // asynchronous reset mid-dwell, pointer returns to zero
        apply_reset();
        set_val(2, 32'h2222_2222);
        dut_if.req_in = 4'b0100;
        tick();
        tick();
        tick();
        chk("t6_pre_src", dut_if.src_out, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_val",    dut_if.val_out,    32'd0);
        chk("t6_async_src",    dut_if.src_out,    32'd0);
        chk("t6_async_valid",  dut_if.valid_out,  32'd0);
        chk("t6_async_switch", dut_if.switch_out, 32'd0);
        dut_if.req_in = 4'b0110;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6_first_grant", dut_if.src_out, 32'd1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6_ptr_cleared", dut_if.src_out, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
